// File: rtl/camera_capture_pkg.sv
// Shared types and constants for the camera capture buffer: FSM states,
// packing ratio and status-word bit positions.
package camera_capture_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2,
    DONE       = 2'd3
  } cap_state_t;

  localparam int PIX_PER_WORD = 4;
  localparam int OVF_BIT      = 31;
  localparam int SHORT_BIT    = 30;

endpackage

// File: rtl/capture_sync_fifo.sv
// Single-clock show-ahead FIFO: o_rd_data is the head word (0 when empty).
// A write into a full FIFO is dropped unless a read frees a slot that cycle.
module capture_sync_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int W          = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_rd;
  logic                  w_do_wr;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign w_do_rd   = i_rd_en & ~o_empty;
  assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_do_wr && !w_do_rd)      r_count <= r_count + CNT_ONE;
      else if (!w_do_wr && w_do_rd) r_count <= r_count - CNT_ONE;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_do_wr && !i_clear) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/camera_capture_buffer.sv
// Captures one frame of pixels, packed four per word, into a show-ahead FIFO
// drained by read toggles. Define CAPTURE_STATUS_WORD_EN to append a status word.
module camera_capture_buffer
  import camera_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int PIX_W      = 8
) (
  input  logic             csi_clk,
  input  logic             csi_reset_n,
  input  logic             capture_start,
  input  logic             capture_read,
  output logic [31:0]      capture_readdata,
  output logic             capture_done,
  input  logic [15:0]      width,
  input  logic [15:0]      height,
  input  logic             frame_valid,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             overflow,
  output logic             underflow,
  output logic             short_frame,
  output logic [1:0]       dbg_state
);

  cap_state_t  r_state;
  cap_state_t  w_next_state;
  logic        r_start_q;
  logic        r_read_q;
  logic        r_fv_q;
  logic [31:0] r_target;
  logic [31:0] r_count;
  logic [31:0] r_pack;
  logic        r_push_valid;
  logic [31:0] r_push_data;
  logic        r_overflow;
  logic        r_underflow;
  logic        r_short;

  logic        w_start_rise;
  logic        w_pop;
  logic        w_fv_rise;
  logic [31:0] w_target_in;
  logic        w_clear;
  logic        w_abort;
  logic        w_flush;
  logic        w_accept;
  logic        w_last;
  logic        w_early;
  logic [1:0]  w_lane;
  logic [31:0] w_pack_next;
  logic        w_push;
  logic [31:0] w_push_data;
  logic        w_fifo_rd;
  logic        w_full;
  logic        w_empty;

  assign w_start_rise = capture_start & ~r_start_q;
  assign w_pop        = capture_read ^ r_read_q;
  assign w_fv_rise    = frame_valid & ~r_fv_q;
  assign w_target_in  = {16'd0, width} * {16'd0, height};
  assign w_clear      = (r_state == IDLE) & w_start_rise;
  assign w_abort      = ((r_state == WAIT_FRAME) | (r_state == CAPTURE)) & ~capture_start;
  assign w_flush      = w_clear | w_abort;
  assign w_accept     = capture_start & frame_valid & pix_valid &
                        ((r_state == CAPTURE) | ((r_state == WAIT_FRAME) & w_fv_rise));
  assign w_last       = w_accept & ((r_count + 32'd1) == r_target);
  assign w_early      = (r_state == CAPTURE) & capture_start & ~frame_valid;
  assign w_lane       = r_count[1:0];
  assign w_fifo_rd    = w_pop & ~w_flush;

  assign capture_done = (r_state == DONE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign short_frame  = r_short;
  assign dbg_state    = r_state;

  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[int'(w_lane)*PIX_W +: PIX_W] = pix_data;
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) r_state <= IDLE;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_rise) w_next_state = (w_target_in == 32'd0) ? DONE : WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!capture_start)  w_next_state = IDLE;
        else if (w_fv_rise)  w_next_state = w_last ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (!capture_start)      w_next_state = IDLE;
        else if (w_last || w_early) w_next_state = DONE;
      end
      DONE: begin
        if (!capture_start) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

`ifdef CAPTURE_STATUS_WORD_EN
  logic        r_status_pend;
  logic [15:0] r_words;
  logic        w_enter_done;

  assign w_enter_done = (w_next_state == DONE) & (r_state != DONE);

  // The status word waits behind any pixel word still in flight.
  always_comb begin
    w_push      = r_push_valid;
    w_push_data = r_push_data;
    if (!r_push_valid && r_status_pend) begin
      w_push                 = 1'b1;
      w_push_data            = '0;
      w_push_data[OVF_BIT]   = r_overflow;
      w_push_data[SHORT_BIT] = r_short;
      w_push_data[15:0]      = r_words;
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      r_status_pend <= 1'b0;
      r_words       <= '0;
    end else if (w_flush) begin
      r_status_pend <= w_clear & (w_target_in == 32'd0);
      if (w_clear) r_words <= '0;
    end else begin
      if (r_push_valid) r_words <= r_words + 16'd1;
      if (w_enter_done)                      r_status_pend <= 1'b1;
      else if (r_status_pend && !r_push_valid) r_status_pend <= 1'b0;
    end
  end
`else
  assign w_push      = r_push_valid;
  assign w_push_data = r_push_data;
`endif

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      r_start_q    <= 1'b0;
      r_read_q     <= 1'b0;
      r_fv_q       <= 1'b0;
      r_target     <= '0;
      r_count      <= '0;
      r_pack       <= '0;
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_short      <= 1'b0;
    end else begin
      r_start_q <= capture_start;
      r_read_q  <= capture_read;
      r_fv_q    <= frame_valid;
      if (w_flush) begin
        r_count      <= '0;
        r_pack       <= '0;
        r_push_valid <= 1'b0;
        if (w_clear) begin
          r_target    <= w_target_in;
          r_overflow  <= 1'b0;
          r_underflow <= 1'b0;
          r_short     <= 1'b0;
        end
      end else begin
        r_push_valid <= 1'b0;
        if (w_accept) begin
          r_count <= r_count + 32'd1;
          if ((w_lane == 2'(PIX_PER_WORD-1)) || w_last) begin
            r_push_valid <= 1'b1;
            r_push_data  <= w_pack_next;
            r_pack       <= '0;
          end else begin
            r_pack <= w_pack_next;
          end
        end else if (w_early) begin
          // Flush a partially filled word before closing out the frame.
          if (w_lane != 2'd0) begin
            r_push_valid <= 1'b1;
            r_push_data  <= r_pack;
          end
          r_pack  <= '0;
          r_short <= 1'b1;
        end
        if (w_push && w_full && !w_fifo_rd) r_overflow  <= 1'b1;
        if (w_fifo_rd && w_empty)           r_underflow <= 1'b1;
      end
    end
  end

  capture_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (32)
  ) u_fifo (
    .i_clk     (csi_clk),
    .i_rst_n   (csi_reset_n),
    .i_clear   (w_flush),
    .i_wr_en   (w_push),
    .i_wr_data (w_push_data),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (capture_readdata),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

endmodule
